// File: rtl/cos_sin_pair_aligner.sv
// Buffers the cos and sin streams independently and re-pairs them in arrival
// order, emitting one AXI4-Stream beat {sin, cos} per pair with point index and end-of-line.
module cos_sin_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   cnt;
  logic          acc;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign acc   = push && ((cnt != FULL_C) || pop);
  assign drop  = push && !acc;
  assign empty = (cnt == '0);
  assign dout  = mem[rdPtr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (acc) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      case ({acc, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (acc) mem[wrPtr] <= din;
  end
endmodule

module cos_sin_pair_aligner #(
  parameter int POINTS_PER_LINE_P = 360,
  parameter int FIFO_DEPTH_P      = 16
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        thetaCos_valid_i,
  input  logic [15:0] thetaCos_i,
  input  logic        thetaSin_valid_i,
  input  logic [15:0] thetaSin_i,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic [31:0] m_axis_tdata_o,
  output logic [11:0] m_axis_tuser_o,
  output logic        m_axis_tlast_o,
  output logic        overflow_o
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 16;
  localparam logic [11:0] LAST_IDX = 12'(POINTS_PER_LINE_P - 1);

  logic [1:0] rstSync;
  logic       rstN;

  // Async assert, release aligned to the clock through two flops.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) rstSync <= '0;
    else         rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  logic [NUM_LANES-1:0]            laneVld, laneEmpty, laneDrop;
  logic [NUM_LANES-1:0][VEC_W-1:0] laneDin, laneHead;
  logic                            load;
  logic [11:0]                     idx;

  // Lane 0 carries cos (X), lane 1 carries sin (Y).
  assign laneVld = {thetaSin_valid_i, thetaCos_valid_i};
  assign laneDin = {thetaSin_i, thetaCos_i};
  assign load    = !(|laneEmpty) && (!m_axis_tvalid_o || m_axis_tready_i);

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    cos_sin_fifo #(.DEPTH(FIFO_DEPTH_P), .W(VEC_W)) uFifo (
      .gclk   (clk_i),
      .grst_n (rstN),
      .push   (laneVld[g]),
      .din    (laneDin[g]),
      .pop    (load),
      .dout   (laneHead[g]),
      .empty  (laneEmpty[g]),
      .drop   (laneDrop[g])
    );
  end

  always_ff @(posedge clk_i or negedge rstN) begin
    if (!rstN) begin
      m_axis_tvalid_o <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tuser_o  <= '0;
      m_axis_tlast_o  <= 1'b0;
      idx             <= '0;
      overflow_o      <= 1'b0;
    end else begin
      if (|laneDrop) overflow_o <= 1'b1;
      if (load) begin
        m_axis_tvalid_o <= 1'b1;
        m_axis_tdata_o  <= {laneHead[1], laneHead[0]};
        m_axis_tuser_o  <= idx;
        m_axis_tlast_o  <= (idx == LAST_IDX);
        idx             <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else if (m_axis_tready_i) begin
        m_axis_tvalid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cos_sin_pair_aligner.sv
// Scoreboard bench for cos_sin_pair_aligner: model queues pair samples in order,
// a negedge monitor checks every accepted beat.
module tb_cos_sin_pair_aligner;
  localparam int PPL   = 360;
  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic        thetaCos_valid_i = 1'b0;
  logic [15:0] thetaCos_i = '0;
  logic        thetaSin_valid_i = 1'b0;
  logic [15:0] thetaSin_i = '0;
  logic        m_axis_tvalid_o;
  logic        m_axis_tready_i = 1'b0;
  logic [31:0] m_axis_tdata_o;
  logic [11:0] m_axis_tuser_o;
  logic        m_axis_tlast_o;
  logic        overflow_o;

  cos_sin_pair_aligner #(.POINTS_PER_LINE_P(PPL), .FIFO_DEPTH_P(DEPTH)) dut (
    .clk_i            (clk_i),
    .nrst_i           (nrst_i),
    .thetaCos_valid_i (thetaCos_valid_i),
    .thetaCos_i       (thetaCos_i),
    .thetaSin_valid_i (thetaSin_valid_i),
    .thetaSin_i       (thetaSin_i),
    .m_axis_tvalid_o  (m_axis_tvalid_o),
    .m_axis_tready_i  (m_axis_tready_i),
    .m_axis_tdata_o   (m_axis_tdata_o),
    .m_axis_tuser_o   (m_axis_tuser_o),
    .m_axis_tlast_o   (m_axis_tlast_o),
    .overflow_o       (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] d;
    logic [11:0] u;
    logic        l;
  } beat_t;

  int          nVec = 0;
  int          nErr = 0;
  int          beatCnt = 0;
  int          lastCnt = 0;
  int          mIdx = 0;
  logic [15:0] cosQ[$];
  logic [15:0] sinQ[$];
  beat_t       expQ[$];

  function automatic void mkPairs();
    beat_t b;
    while (cosQ.size() > 0 && sinQ.size() > 0) begin
      b.d = {sinQ[0], cosQ[0]};
      void'(sinQ.pop_front());
      void'(cosQ.pop_front());
      b.u = 12'(mIdx);
      b.l = (mIdx == PPL - 1);
      expQ.push_back(b);
      mIdx = (mIdx == PPL - 1) ? 0 : mIdx + 1;
    end
  endfunction

  // Scoreboard monitor: every handshake must match the oldest expected pair.
  always @(negedge clk_i) begin
    beat_t e;
    if (nrst_i && m_axis_tvalid_o && m_axis_tready_i) begin
      beatCnt++;
      if (m_axis_tlast_o) lastCnt++;
      nVec++;
      if (expQ.size() == 0) begin
        nErr++;
        $display("FAIL unexpected_beat: got tdata=%h tuser=%0d, none expected", m_axis_tdata_o, m_axis_tuser_o);
      end else begin
        e = expQ.pop_front();
        if ({m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o} !== {e.d, e.u, e.l}) begin
          nErr++;
          $display("FAIL beat: got tdata=%h tuser=%0d tlast=%b, want tdata=%h tuser=%0d tlast=%b",
                   m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, e.d, e.u, e.l);
        end
      end
    end
  end

  task automatic drv(input logic cv, input logic [15:0] c, input logic sv, input logic [15:0] s,
                     input logic rdy, input bit keepC = 1, input bit keepS = 1);
    @(posedge clk_i); #1;
    thetaCos_valid_i = cv; thetaCos_i = c;
    thetaSin_valid_i = sv; thetaSin_i = s;
    m_axis_tready_i  = rdy;
    if (cv && keepC) cosQ.push_back(c);
    if (sv && keepS) sinQ.push_back(s);
    mkPairs();
  endtask

  task automatic doReset();
    nrst_i = 1'b0;
    thetaCos_valid_i = 1'b0; thetaSin_valid_i = 1'b0; m_axis_tready_i = 1'b0;
    cosQ.delete(); sinQ.delete(); expQ.delete(); mIdx = 0;
    repeat (3) @(posedge clk_i);
    #1 nrst_i = 1'b1;
    repeat (3) @(posedge clk_i);
  endtask

  task automatic drain(input int maxCyc, input string name);
    int n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      @(posedge clk_i); n++;
    end
    nVec++;
    if (expQ.size() != 0) begin
      nErr++;
      $display("FAIL %s_drain_timeout: %0d beats still pending, want 0", name, expQ.size());
    end
    @(negedge clk_i); @(negedge clk_i);
    nVec++;
    if (m_axis_tvalid_o !== 1'b0) begin
      nErr++;
      $display("FAIL %s_extra_beat: tvalid=%b after drain, want 0", name, m_axis_tvalid_o);
    end
  endtask

  task automatic test_reset();
    nrst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    nVec++;
    if ({m_axis_tvalid_o, m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, overflow_o} !== '0) begin
      nErr++;
      $display("FAIL reset_outputs: tvalid=%b tdata=%h tuser=%0d tlast=%b ovf=%b, want all 0",
               m_axis_tvalid_o, m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, overflow_o);
    end
    doReset();
    @(negedge clk_i);
    nVec++;
    if ({m_axis_tvalid_o, overflow_o} !== 2'b00) begin
      nErr++;
      $display("FAIL post_reset: tvalid=%b ovf=%b, want 0 0", m_axis_tvalid_o, overflow_o);
    end
  endtask

  task automatic test_latency();
    int b0;
    doReset();
    b0 = beatCnt;
    for (int i = 0; i < 4; i++) drv(1'b1, 16'h1000 + 16'(i), 1'b0, '0, 1'b1);
    drv(1'b0, '0, 1'b0, '0, 1'b1);
    drv(1'b0, '0, 1'b1, 16'h0F00, 1'b1);
    drv(1'b0, '0, 1'b1, 16'h0F01, 1'b1);
    @(negedge clk_i);
    nVec++;
    if (m_axis_tvalid_o !== 1'b0) begin
      nErr++;
      $display("FAIL latency_early: tvalid=%b at sin edge, want 0", m_axis_tvalid_o);
    end
    drv(1'b0, '0, 1'b1, 16'h0F02, 1'b1);
    @(negedge clk_i);
    nVec++;
    if (m_axis_tvalid_o !== 1'b1) begin
      nErr++;
      $display("FAIL latency_first: tvalid=%b one edge after sin, want 1", m_axis_tvalid_o);
    end
    drv(1'b0, '0, 1'b1, 16'h0F03, 1'b1);
    drv(1'b0, '0, 1'b0, '0, 1'b1);
    drain(20, "latency");
    nVec++;
    if (beatCnt - b0 != 4) begin
      nErr++;
      $display("FAIL latency_count: got %0d beats, want 4", beatCnt - b0);
    end
  endtask

  task automatic test_stream();
    int b0, l0;
    doReset();
    b0 = beatCnt; l0 = lastCnt;
    for (int i = 0; i < 720; i++) drv(1'b1, 16'(i), 1'b1, 16'(i) ^ 16'hA5A5, 1'b1);
    drv(1'b0, '0, 1'b0, '0, 1'b1);
    drain(10, "stream");
    nVec++;
    if (beatCnt - b0 != 720 || lastCnt - l0 != 2) begin
      nErr++;
      $display("FAIL stream_count: got %0d beats %0d tlast, want 720 2", beatCnt - b0, lastCnt - l0);
    end
    nVec++;
    if (overflow_o !== 1'b0) begin
      nErr++;
      $display("FAIL stream_overflow: ovf=%b, want 0", overflow_o);
    end
  endtask

  task automatic test_stall();
    int b0;
    doReset();
    b0 = beatCnt;
    for (int i = 0; i < 17; i++) drv(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk_i);
      nVec++;
      if (m_axis_tvalid_o !== 1'b1 || m_axis_tdata_o !== expQ[0].d || m_axis_tuser_o !== expQ[0].u) begin
        nErr++;
        $display("FAIL stall_hold: tvalid=%b tdata=%h tuser=%0d, want 1 %h %0d",
                 m_axis_tvalid_o, m_axis_tdata_o, m_axis_tuser_o, expQ[0].d, expQ[0].u);
      end
    end
    nVec++;
    if (overflow_o !== 1'b0) begin
      nErr++;
      $display("FAIL stall_overflow: ovf=%b with 16 queued, want 0", overflow_o);
    end
    drv(1'b0, '0, 1'b0, '0, 1'b1);
    drain(40, "stall");
    nVec++;
    if (beatCnt - b0 != 17) begin
      nErr++;
      $display("FAIL stall_count: got %0d beats, want 17", beatCnt - b0);
    end
  endtask

  task automatic test_overflow();
    int b0;
    doReset();
    b0 = beatCnt;
    for (int i = 0; i < 17; i++) drv(1'b1, 16'h2000 + 16'(i), 1'b1, 16'h3000 + 16'(i), 1'b0);
    drv(1'b1, 16'h20FF, 1'b1, 16'h30FF, 1'b0, 0, 0);
    repeat (3) drv(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk_i);
    nVec++;
    if (overflow_o !== 1'b1) begin
      nErr++;
      $display("FAIL overflow_set: ovf=%b after 18th push, want 1", overflow_o);
    end
    drv(1'b0, '0, 1'b0, '0, 1'b1);
    drain(40, "overflow");
    nVec++;
    if (beatCnt - b0 != 17 || overflow_o !== 1'b1) begin
      nErr++;
      $display("FAIL overflow_drain: got %0d beats ovf=%b, want 17 1", beatCnt - b0, overflow_o);
    end
  endtask

  task automatic test_push_pop_full();
    int b0;
    doReset();
    b0 = beatCnt;
    for (int i = 0; i < 17; i++) drv(1'b1, 16'h4000 + 16'(i), 1'b1, 16'h5000 + 16'(i), 1'b0);
    for (int i = 17; i < 23; i++) drv(1'b1, 16'h4000 + 16'(i), 1'b1, 16'h5000 + 16'(i), 1'b1);
    drv(1'b0, '0, 1'b0, '0, 1'b1);
    drain(40, "pushpop");
    nVec++;
    if (beatCnt - b0 != 23 || overflow_o !== 1'b0) begin
      nErr++;
      $display("FAIL pushpop_full: got %0d beats ovf=%b, want 23 0", beatCnt - b0, overflow_o);
    end
  endtask

  task automatic test_mid_reset();
    int b0;
    doReset();
    drv(1'b1, 16'h6000, 1'b1, 16'h7000, 1'b0);
    for (int i = 1; i < 4; i++) drv(1'b1, 16'h6000 + 16'(i), 1'b0, '0, 1'b0);
    drv(1'b0, '0, 1'b0, '0, 1'b0);
    @(negedge clk_i);
    nVec++;
    if (m_axis_tvalid_o !== 1'b1) begin
      nErr++;
      $display("FAIL midreset_pre: tvalid=%b before reset, want 1", m_axis_tvalid_o);
    end
    #1 nrst_i = 1'b0;
    #1;
    nVec++;
    if ({m_axis_tvalid_o, m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o} !== '0) begin
      nErr++;
      $display("FAIL midreset_async: tvalid=%b tdata=%h tuser=%0d tlast=%b, want all 0",
               m_axis_tvalid_o, m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o);
    end
    doReset();
    b0 = beatCnt;
    drv(1'b0, '0, 1'b1, 16'h7ABC, 1'b1);
    repeat (3) drv(1'b0, '0, 1'b0, '0, 1'b1);
    @(negedge clk_i);
    nVec++;
    if (m_axis_tvalid_o !== 1'b0) begin
      nErr++;
      $display("FAIL midreset_stale: tvalid=%b with only sin pushed, want 0", m_axis_tvalid_o);
    end
    drv(1'b1, 16'h6ABC, 1'b0, '0, 1'b1);
    drv(1'b0, '0, 1'b0, '0, 1'b1);
    drain(10, "midreset");
    nVec++;
    if (beatCnt - b0 != 1) begin
      nErr++;
      $display("FAIL midreset_count: got %0d beats, want 1", beatCnt - b0);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_stall();
    test_overflow();
    test_push_pop_full();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
